// File: rtl/mem_dumper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_dumper_pkg
// Brief    : Shared defaults and FSM state encoding for the memory dumper.
// Revision : 1.0 - initial release
// ============================================================================
package mem_dumper_pkg;

    localparam int c_depth  = 32;
    localparam int c_addr_w = 5;
    localparam int c_data_w = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_WAIT = 3'd2,
        ST_SEND = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_dumper.sv
`default_nettype none
// ============================================================================
// Module   : mem_dumper
// Brief    : Streams a wrapping address window of an external memory out over
//            a valid/ready interface, one entry per read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_dumper
    import mem_dumper_pkg::*;
#(
    parameter int DEPTH  = c_depth,
    parameter int ADDR_W = c_addr_w,
    parameter int DATA_W = c_data_w
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] c_len_full = (ADDR_W+1)'(DEPTH);

    state_t              r_state;
    state_t              w_next_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W:0]     r_remaining;
    logic [DATA_W-1:0]   r_out_data;
    logic [ADDR_W-1:0]   r_out_addr;
    logic                r_out_last;
    logic                w_load;
    logic                w_capture;
    logic                w_advance;
    logic [ADDR_W:0]     w_len_resolved;

    // A zero length request means a full-memory dump.
    assign w_len_resolved = (len == '0) ? c_len_full : len;

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_capture    = 1'b0;
        w_advance    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_load       = 1'b1;
                    w_next_state = ST_READ;
                end
            end
            ST_READ: w_next_state = ST_WAIT;
            ST_WAIT: begin
                w_capture    = 1'b1;
                w_next_state = ST_SEND;
            end
            ST_SEND: begin
                if (out_ready) begin
                    if (r_out_last) begin
                        w_next_state = ST_DONE;
                    end else begin
                        w_advance    = 1'b1;
                        w_next_state = ST_READ;
                    end
                end
            end
            ST_DONE: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
        // Abort overrides every transition and suppresses datapath updates.
        if (abort && (r_state != ST_IDLE)) begin
            w_next_state = ST_IDLE;
            w_capture    = 1'b0;
            w_advance    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_load) begin
                r_addr      <= base_addr;
                r_remaining <= w_len_resolved;
            end else if (w_advance) begin
                // Power-of-two depth: natural overflow gives the wrap to 0.
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - (ADDR_W+1)'(1);
            end
            if (w_capture) begin
                r_out_data <= mem_rdata;
                r_out_addr <= r_addr;
                r_out_last <= (r_remaining == (ADDR_W+1)'(1));
            end
        end
    end

    // All control outputs decode the registered state only, so out_valid
    // never sees out_ready combinationally.
    assign mem_rd_en = (r_state == ST_READ);
    assign mem_addr  = r_addr;
    assign out_valid = (r_state == ST_SEND);
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_last  = r_out_last;
    assign busy      = (r_state != ST_IDLE);
    assign done      = (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_mem_dumper.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_dumper
// Brief    : Self-checking bench for mem_dumper with a behavioural memory.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_dumper;
    import mem_dumper_pkg::*;

    localparam int DEPTH = c_depth;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] base_addr = '0;
    logic [5:0] len = '0;
    logic       mem_rd_en;
    logic [4:0] mem_addr;
    logic [7:0] mem_rdata = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [4:0] out_addr;
    logic       out_last;
    logic       busy;
    logic       done;

    logic [7:0] mem [DEPTH];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;

    typedef struct {
        int base;
        int ln;
        int mode;
        int stall_n;
        int poke_at;
        int exp_faddr;
        int exp_fdata;
        int exp_laddr;
        int exp_ldata;
        int exp_lat;
    } vec_t;

    vec_t vecs[6];

    mem_dumper dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .base_addr (base_addr),
        .len       (len),
        .mem_rd_en (mem_rd_en),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_addr  (out_addr),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd_en) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic preload_ramp();
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 'h10);
    endtask

    // mode 0: ready always high; 1: random ready; 2: stall first beat stall_n cycles
    task automatic do_dump(input int b, input int l, input int mode, input int stall_n,
                           input int poke_at, output int f_addr, output int f_data,
                           output int l_addr, output int l_data, output int lat);
        int  n, beat, stalls, reads, t0, k, limit, exp_addr;
        bit  got_done, held, rdy;
        logic [7:0] hold_data;
        n = (l == 0) ? DEPTH : l;
        f_addr = -1; f_data = -1; l_addr = -1; l_data = -1; lat = -1;
        beat = 0; stalls = 0; reads = 0; k = 0; got_done = 0; held = 0;
        hold_data = '0;
        limit = 3 * n + stall_n + 2000;
        @(negedge clk);
        start = 1'b1; base_addr = 5'(b); len = 6'(l); out_ready = 1'b1;
        t0 = cyc;
        while (!got_done && k < limit) begin
            @(negedge clk);
            k++;
            if (poke_at != 0 && k == poke_at) begin
                start = 1'b1; base_addr = 5'(b + 9); len = 6'd3;
            end else begin
                start = 1'b0;
            end
            if (mem_rd_en) reads++;
            if (out_valid) begin
                exp_addr = (b + beat) % DEPTH;
                chk("beat_addr", int'(out_addr), exp_addr);
                chk("beat_data", int'(out_data), int'(mem[exp_addr]));
                chk("beat_last", int'(out_last), (beat == n - 1) ? 1 : 0);
                if (held) chk("stall_hold", int'(out_data), int'(hold_data));
                case (mode)
                    1:       rdy = ($urandom_range(0, 3) != 0);
                    2:       rdy = !(beat == 0 && stalls < stall_n);
                    default: rdy = 1'b1;
                endcase
                out_ready = rdy;
                if (rdy) begin
                    if (beat == 0) begin f_addr = exp_addr; f_data = int'(out_data); end
                    l_addr = exp_addr; l_data = int'(out_data);
                    beat++;
                    held = 1'b0;
                end else begin
                    stalls++;
                    held = 1'b1;
                    hold_data = out_data;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            if (done) begin
                got_done = 1'b1;
                lat = cyc - t0;
            end
        end
        start = 1'b0;
        if (!got_done) begin
            chk("dump_timeout", 0, 1);
        end else begin
            chk("beat_count", beat, n);
            chk("read_count", reads, n);
            chk("latency_model", lat, 3 * n + 1 + stalls);
            @(negedge clk);
            chk("done_one_cycle", int'(done), 0);
            chk("idle_after_done", int'(busy), 0);
        end
    endtask

    initial begin
        int fa, fd, la, ld, lt, k, seen, cnt;
        bit act;

        vecs[0] = '{0,  0,  0, 0,  0, 0,  'h10, 31, 'h2F, 97};
        vecs[1] = '{30, 4,  0, 0,  0, 30, 'h2E, 1,  'h11, 13};
        vecs[2] = '{5,  2,  2, 10, 0, 5,  'h15, 6,  'h16, 17};
        vecs[3] = '{31, 1,  0, 0,  0, 31, 'h2F, 31, 'h2F, 4};
        vecs[4] = '{12, 32, 0, 0,  0, 12, 'h1C, 11, 'h1B, 97};
        vecs[5] = '{3,  3,  0, 0,  5, 3,  'h13, 5,  'h15, 10};
        preload_ramp();

        // Reset state
        #12;
        chk("reset_outputs", int'({mem_rd_en, mem_addr, out_valid, out_data, out_addr,
                                   out_last, busy, done}), 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", int'({busy, mem_rd_en, out_valid, done}), 0);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            do_dump(vecs[i].base, vecs[i].ln, vecs[i].mode, vecs[i].stall_n, vecs[i].poke_at,
                    fa, fd, la, ld, lt);
            chk($sformatf("vec%0d_first_addr", i), fa, vecs[i].exp_faddr);
            chk($sformatf("vec%0d_first_data", i), fd, vecs[i].exp_fdata);
            chk($sformatf("vec%0d_last_addr", i), la, vecs[i].exp_laddr);
            chk($sformatf("vec%0d_last_data", i), ld, vecs[i].exp_ldata);
            chk($sformatf("vec%0d_latency", i), lt, vecs[i].exp_lat);
        end

        // Abort during the second SEND of a len 8 dump
        @(negedge clk);
        start = 1'b1; base_addr = 5'd20; len = 6'd8; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0; k = 0;
        while (seen < 2 && k < 100) begin
            if (out_valid) seen++;
            if (seen < 2) begin @(negedge clk); k++; end
        end
        chk("abort_reached_send2", seen, 2);
        chk("abort_send2_addr", int'(out_addr), 21);
        abort = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_valid_drop", int'(out_valid), 0);
        chk("abort_idle", int'(busy), 0);
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy || mem_rd_en) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        do_dump(17, 5, 0, 0, 0, fa, fd, la, ld, lt);
        chk("post_abort_last", ld, 'h25);

        // Abort and start together in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1; base_addr = 5'd2; len = 6'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        act = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (busy || mem_rd_en || out_valid) act = 1'b1;
            @(negedge clk);
        end
        chk("abort_start_ignored", int'(act), 0);

        // Asynchronous reset during WAIT
        start = 1'b1; base_addr = 5'd7; len = 6'd4; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("pre_reset_read", int'(mem_rd_en), 1);
        @(posedge clk);
        #2;
        chk("pre_reset_busy", int'(busy), 1);
        rst = 1'b0;
        #1;
        chk("async_reset_outputs", int'({mem_rd_en, mem_addr, out_valid, out_data, out_addr,
                                        out_last, busy, done}), 0);
        @(negedge clk);
        rst = 1'b1;
        act = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || mem_rd_en || out_valid || done) act = 1'b1;
        end
        chk("post_reset_quiet", int'(act), 0);

        // Randomized dumps over random memory contents
        for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom_range(0, 255));
        for (int t = 0; t < 15; t++) begin
            int b, l, n;
            b = $urandom_range(0, 31);
            l = $urandom_range(0, 32);
            n = (l == 0) ? DEPTH : l;
            do_dump(b, l, 1, 0, 0, fa, fd, la, ld, lt);
            chk("rand_first_addr", fa, b);
            chk("rand_last_addr", la, (b + n - 1) % DEPTH);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_dumper.md
MEM_DUMPER -- requirements
Module: mem_dumper

Interface
REQ-001 Parameter DEPTH, default 32, number of memory entries.
REQ-002 Parameter ADDR_W, default 5, address width, DEPTH = 2**ADDR_W.
REQ-003 Parameter DATA_W, default 8, memory entry width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a dump.
REQ-007 abort  input  1  terminate the current dump.
REQ-008 base_addr  input  ADDR_W  first address to read, sampled on accepted start.
REQ-009 len  input  ADDR_W+1  entries to dump, sampled on accepted start; 0 means DEPTH.
REQ-010 mem_rd_en  output  1  memory read strobe.
REQ-011 mem_addr  output  ADDR_W  memory read address.
REQ-012 mem_rdata  input  DATA_W  read data, valid exactly one cycle after mem_rd_en.
REQ-013 out_valid  output  1  out_data, out_addr and out_last are valid.
REQ-014 out_ready  input  1  consumer accepts the output beat.
REQ-015 out_data  output  DATA_W  dumped entry.
REQ-016 out_addr  output  ADDR_W  address of the dumped entry.
REQ-017 out_last  output  1  final beat of the dump.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 done  output  1  one-cycle pulse after the last beat is accepted.

Function
REQ-020 FSM states: IDLE, READ, WAIT, SEND, DONE.
REQ-021 IDLE with start=1: latch base_addr into the address counter and the resolved len (1..DEPTH) into the remaining counter, then go to READ.
REQ-022 READ: drive mem_rd_en=1 and mem_addr=address counter for one cycle, then go to WAIT.
REQ-023 WAIT: register mem_rdata into out_data and the address into out_addr; set out_last when remaining==1; go to SEND.
REQ-024 SEND: hold out_valid=1 with out_data, out_addr and out_last stable until out_valid and out_ready are both high in the same cycle.
REQ-025 On the SEND handshake with out_last=1, go to DONE; otherwise increment the address modulo DEPTH, decrement remaining, and go to READ.
REQ-026 DONE: assert done=1 for one cycle, then go to IDLE.
REQ-027 The address wraps from DEPTH-1 to 0; for example, base 30 with len 4 reads 30, 31, 0, 1.
REQ-028 start is ignored when the FSM is not in IDLE.
REQ-029 abort has priority over every other transition: in any non-IDLE state the next state is IDLE, out_valid drops, and done does not pulse.
REQ-030 abort and start asserted in the same IDLE cycle: abort wins, and no dump starts.
REQ-031 mem_rd_en is high only in READ, so each entry is read exactly once.
REQ-032 Minimum cost is 3 cycles per entry with out_ready held high; dump latency is 3*len+1 cycles from the start cycle to the done pulse.
REQ-033 out_valid does not depend combinationally on out_ready.

Reset
REQ-034 While rst=0, state=IDLE, and the counters, mem_rd_en, mem_addr, out_valid, out_data, out_addr, out_last, busy and done are all 0.
REQ-035 Reset asserted mid-dump takes effect immediately (asynchronously); after release the block is in IDLE and requires a new start.

Structure
REQ-036 A shared package holds the FSM state encoding and the DEPTH, ADDR_W and DATA_W defaults for reuse by the core, the memories and the testbench.
REQ-037 The block is a single module with no sub-modules; the memory stays external.

Verification
REQ-038 Memory preloaded so mem[i]=i+8'h10; start, base 0, len 0, out_ready=1 -> 32 beats 8'h10..8'h2F, out_addr 0..31, out_last only on addr 31, done at cycle 97 after start.
REQ-039 base 30, len 4 -> out_addr sequence 30, 31, 0, 1, with data 8'h2E, 8'h2F, 8'h10, 8'h11.
REQ-040 base 5, len 2, out_ready low for 10 cycles on the first beat -> out_data 8'h15 held stable, no extra mem_rd_en, and second beat 8'h16 follows.
REQ-041 abort during the second SEND of a len 8 dump -> IDLE next cycle, out_valid=0, no done; a new start then dumps correctly.
REQ-042 start pulsed while busy -> ignored, and the original dump completes unchanged.
REQ-043 rst driven low during WAIT -> all outputs 0 asynchronously; after rst goes high, no activity occurs until start.
